sseg_capture: RTL
=================

SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical synchronized samples required before a capture.
REQ-002 SHALL have port clk  input  1  system clock; all flops rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port an  input  8  multiplexed digit enables, active-low, one-hot-low when valid.
REQ-005 SHALL have port sseg  input  8  segment lines, active-low; [6:0] segments g..a, [7] decimal point.
REQ-006 SHALL have port digits  output  32  captured hex values; digit i at bits [4i+3:4i].
REQ-007 SHALL have port valid  output  8  bit i set when slot i holds a decoded hex value.
REQ-008 SHALL have port seg_err  output  8  bit i set when the last capture for slot i was an illegal segment pattern.
REQ-009 SHALL have port dp  output  8  captured decimal-point state per slot, 1 = lit.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when all 8 slots have been captured since the previous pulse.
REQ-011 SHALL have port an_err  output  1  one-cycle pulse when a stable an pattern is neither one-hot-low nor 8'hFF.

Function
REQ-012 SHALL pass an and sseg through 2-flop synchronizers; all further logic uses the synchronized values.
REQ-013 SHALL keep a stability counter: it resets to 0 when the synchronized {an,sseg} differs from its previous-cycle value, else increments and saturates at STABLE_CYCLES-1.
REQ-014 SHALL perform exactly one capture per stable period: on the edge where the counter reaches STABLE_CYCLES-1; no recapture until {an,sseg} changes.
REQ-015 SHALL make capture results visible on outputs one cycle after the capture edge; pin-to-output latency = 2 + STABLE_CYCLES + 1 cycles.
REQ-016 SHALL, on capture with an one-hot-low at bit i, decode sseg[6:0]: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex codes).
REQ-017 SHALL, for a legal code, write the nibble to slot i, set valid[i], clear seg_err[i].
REQ-018 SHALL, for sseg[6:0]=7F (blank), leave slot i unchanged, clear valid[i], clear seg_err[i].
REQ-019 SHALL, for any other code, leave slot i unchanged, clear valid[i], set seg_err[i].
REQ-020 SHALL mark slot i seen on every capture of that slot, regardless of decode result.
REQ-021 SHALL ignore captures with an=8'hFF: no slot update, no error.
REQ-022 SHALL, on capture with an not one-hot-low and not FF, pulse an_err, update nothing, mark nothing seen.
REQ-023 SHALL pulse frame_done the cycle after the capture that completes the seen mask, and clear the seen mask in the same edge; that capture counts toward the completed frame only.
REQ-024 SHALL allow repeated captures of an already-seen slot within a frame; the latest overwrites, seen unchanged.

Reset
REQ-025 SHALL, while reset_n=0, clear synchronizers, counter, seen mask, digits=0, valid=0, seg_err=0, dp=0, frame_done=0, an_err=0.
REQ-026 SHALL abandon any partial frame or stable period on reset mid-operation; after release the counter starts from 0.

Configuration
REQ-027 SHALL honour macro SSEG_CAPTURE_DP_EN: defined -> on a slot capture dp[i] = ~sseg[7] (all decode outcomes); undefined -> dp tied to 8'h00 and sseg[7] ignored (including in change detection).

Verification
REQ-028 SHALL cover: reset, drive an=FE, sseg=40 for 10 cycles -> digits[3:0]=0, valid=01 exactly 7 cycles after first drive (STABLE_CYCLES=4).
REQ-029 SHALL cover: scan an FE..7F each held 8 cycles with codes for 0..7 -> digits=32'h76543210, valid=FF, one frame_done pulse after slot 7 capture.
REQ-030 SHALL cover: an=FB, sseg=55 held -> seg_err=04, valid[2]=0, digits[11:8] unchanged; then sseg=7F -> seg_err[2]=0, valid[2]=0.
REQ-031 SHALL cover: an=FC held 10 cycles -> single an_err pulse, outputs unchanged; sseg glitch every 3 cycles with STABLE_CYCLES=4 -> no capture.
REQ-032 SHALL cover: with SSEG_CAPTURE_DP_EN, an=EF, sseg=79 -> dp=10, digits[19:16]=1; without the macro dp=00; reset_n low mid-frame -> all outputs 0, frame_done only after 8 new captures.

Source files
------------

// File: rtl/sseg_capture.sv
// Recovers the digits shown on a multiplexed, active-low seven-segment display by sampling its pins.
// Optional decimal-point capture is enabled by defining SSEG_CAPTURE_DP_EN.
module sseg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  an,
    input  logic [7:0]  sseg,
    output logic [31:0] digits,
    output logic [7:0]  valid,
    output logic [7:0]  seg_err,
    output logic [7:0]  dp,
    output logic        frame_done,
    output logic        an_err
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

`ifdef SSEG_CAPTURE_DP_EN
    localparam logic [7:0] SSEG_MASK = 8'hFF;
`else
    // Without dp capture the dp line must not restart the stability count.
    localparam logic [7:0] SSEG_MASK = 8'h7F;
`endif

    logic [7:0]    an_s1, an_s2, sseg_s1, sseg_s2;
    logic [15:0]   prev;
    logic [CW-1:0] cnt;
    logic          changed, capture;
    logic          cap_pend;
    logic [7:0]    cap_an;
    logic [6:0]    cap_seg;
    logic [7:0]    an_low, seen, seen_nxt;
    logic          one_hot, legal, blank;
    logic [3:0]    nib;

    assign changed = {an_s2, sseg_s2} != prev;
    assign capture = !changed && (cnt == CNT_CAP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_s1    <= '0;
            an_s2    <= '0;
            sseg_s1  <= '0;
            sseg_s2  <= '0;
            prev     <= '0;
            cnt      <= '0;
            cap_pend <= 1'b0;
            cap_an   <= '0;
            cap_seg  <= '0;
        end else begin
            an_s1    <= an;
            an_s2    <= an_s1;
            sseg_s1  <= sseg & SSEG_MASK;
            sseg_s2  <= sseg_s1;
            prev     <= {an_s2, sseg_s2};
            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            cap_pend <= capture;
            if (capture) begin
                cap_an  <= an_s2;
                cap_seg <= sseg_s2[6:0];
            end
        end
    end

    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (cap_seg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
        blank    = cap_seg == 7'h7F;
        an_low   = ~cap_an;
        one_hot  = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
        seen_nxt = seen | an_low;
    end

`ifdef SSEG_CAPTURE_DP_EN
    logic cap_dp;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_dp <= 1'b0;
            dp     <= '0;
        end else begin
            if (capture)
                cap_dp <= ~sseg_s2[7];
            if (cap_pend && one_hot)
                for (int i = 0; i < 8; i++)
                    if (an_low[i])
                        dp[i] <= cap_dp;
        end
    end
`else
    assign dp = 8'h00;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits     <= '0;
            valid      <= '0;
            seg_err    <= '0;
            seen       <= '0;
            frame_done <= 1'b0;
            an_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            an_err     <= 1'b0;
            if (cap_pend && cap_an != 8'hFF) begin
                if (one_hot) begin
                    for (int i = 0; i < 8; i++) begin
                        if (an_low[i]) begin
                            if (legal)
                                digits[4*i +: 4] <= nib;
                            valid[i]   <= legal;
                            seg_err[i] <= !legal && !blank;
                        end
                    end
                    // The completing capture closes this frame; the next one starts empty.
                    if (seen_nxt == 8'hFF) begin
                        seen       <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        seen <= seen_nxt;
                    end
                end else begin
                    an_err <= 1'b1;
                end
            end
        end
    end

endmodule
